// File: rtl/bsg_adder_chunked_serial_if.sv
// Handshake bundle for the chunked serial adder: an operand pair in over
// valid/ready and a result out over valid/yumi.
interface bsg_adder_chunked_serial_if #(
    parameter int width_p = 32
);
    logic               v_i;
    logic [width_p-1:0] a_i;
    logic [width_p-1:0] b_i;
    logic               sub_i;
    logic               ready_o;
    logic               v_o;
    logic [width_p-1:0] sum_o;
    logic               c_o;
    logic               ovf_o;
    logic               yumi_i;

    // Adder side
    modport slave (
        input  v_i, a_i, b_i, sub_i, yumi_i,
        output ready_o, v_o, sum_o, c_o, ovf_o
    );

    // Producer/consumer side
    modport master (
        output v_i, a_i, b_i, sub_i, yumi_i,
        input  ready_o, v_o, sum_o, c_o, ovf_o
    );
endinterface

// File: rtl/bsg_adder_chunked_serial.sv
// Multi-cycle adder/subtractor: ripples a registered carry across
// width_p/chunk_p slices, one slice per cycle, then holds the result
// until the consumer takes it.
module bsg_adder_chunked_serial #(
    parameter int width_p = 32,
    parameter int chunk_p = 8
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    bsg_adder_chunked_serial_if.slave   io
);
    localparam int chunks_lp    = width_p / chunk_p;
    localparam int cnt_width_lp = (chunks_lp > 1) ? $clog2(chunks_lp) : 1;

    if (chunk_p < 1) begin : g_bad_chunk
        $error("bsg_adder_chunked_serial: chunk_p must be >= 1");
    end else if ((width_p % chunk_p) != 0) begin : g_bad_width
        $error("bsg_adder_chunked_serial: width_p must be a multiple of chunk_p");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e                  state_r;
    logic [width_p-1:0]      a_r;
    logic [width_p-1:0]      b_r;
    logic [width_p-1:0]      sum_r;
    logic [cnt_width_lp-1:0] count_r;
    logic                    carry_r;
    logic                    c_r;
    logic                    ovf_r;
    logic                    sign_a_r;
    logic                    sign_b_r;

    logic [chunk_p-1:0]      a_slice;
    logic [chunk_p-1:0]      b_slice;
    logic [chunk_p:0]        slice_sum;

    // Current slice of both operands and their sum with the running carry
    always_comb begin
        a_slice   = a_r[int'(count_r)*chunk_p +: chunk_p];
        b_slice   = b_r[int'(count_r)*chunk_p +: chunk_p];
        slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + {{chunk_p{1'b0}}, carry_r};
    end

    // Control FSM and datapath registers; reset discards any partial result
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r  <= IDLE;
            count_r  <= '0;
            carry_r  <= 1'b0;
            sum_r    <= '0;
            c_r      <= 1'b0;
            ovf_r    <= 1'b0;
            a_r      <= '0;
            b_r      <= '0;
            sign_a_r <= 1'b0;
            sign_b_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (io.v_i) begin
                        a_r      <= io.a_i;
                        b_r      <= io.sub_i ? ~io.b_i : io.b_i;
                        carry_r  <= io.sub_i;
                        count_r  <= '0;
                        sign_a_r <= io.a_i[width_p-1];
                        sign_b_r <= io.sub_i ? ~io.b_i[width_p-1] : io.b_i[width_p-1];
                        state_r  <= BUSY;
                    end
                end
                BUSY: begin
                    sum_r[int'(count_r)*chunk_p +: chunk_p] <= slice_sum[chunk_p-1:0];
                    carry_r <= slice_sum[chunk_p];
                    if (count_r == cnt_width_lp'(chunks_lp - 1)) begin
                        c_r     <= slice_sum[chunk_p];
                        ovf_r   <= (sign_a_r == sign_b_r) &&
                                   (slice_sum[chunk_p-1] != sign_a_r);
                        state_r <= DONE;
                    end else begin
                        count_r <= count_r + 1'b1;
                    end
                end
                DONE: begin
                    if (io.yumi_i) begin
                        state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    assign io.ready_o = (state_r == IDLE);
    assign io.v_o     = (state_r == DONE);
    assign io.sum_o   = sum_r;
    assign io.c_o     = c_r;
    assign io.ovf_o   = ovf_r;

    // Consumer must only take a result that is actually presented
    yumi_only_when_valid: assert property (
        @(posedge clk_i) disable iff (!reset_n_i) io.yumi_i |-> io.v_o
    );
endmodule

// File: tb/tb_bsg_adder_chunked_serial.sv
// Bench for bsg_adder_chunked_serial: directed corner cases on a chunk_p=8
// instance plus randomized traffic on chunk_p=8/32/1 instances, all checked
// against plain-arithmetic expectations.
module tb_bsg_adder_chunked_serial;
    logic clk = 1'b0;
    logic rst_dir;
    logic rst_rand;
    int   n_vec = 0;
    int   n_err = 0;

    localparam int NOPS = 200;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- directed instance ----------------
    bsg_adder_chunked_serial_if #(.width_p(32)) d_if ();
    bsg_adder_chunked_serial #(.width_p(32), .chunk_p(8)) u_dir (
        .clk_i    (clk),
        .reset_n_i(rst_dir),
        .io       (d_if.slave)
    );

    task automatic do_dir(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic [31:0] es, input logic ec, input logic eo);
        int n;
        n = 0;
        while (!d_if.ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        d_if.v_i   = 1'b1;
        d_if.a_i   = a;
        d_if.b_i   = b;
        d_if.sub_i = sub;
        @(negedge clk);
        d_if.v_i = 1'b0;
        n = 0;
        while (!d_if.v_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'd4);
        check({tag, "_res"}, {30'd0, d_if.c_o, d_if.ovf_o, d_if.sum_o}, {30'd0, ec, eo, es});
        if (d_if.v_o) begin
            d_if.yumi_i = 1'b1;
            @(negedge clk);
            d_if.yumi_i = 1'b0;
        end
        check({tag, "_rdy"}, {62'd0, d_if.ready_o, d_if.v_o}, 64'b10);
    endtask

    // ---------------- randomized instances ----------------
    for (genvar g = 0; g < 3; g++) begin : g_rand
        localparam int CH  = (g == 0) ? 8 : (g == 1) ? 32 : 1;
        localparam int NCH = 32 / CH;
        logic done = 1'b0;

        bsg_adder_chunked_serial_if #(.width_p(32)) r_if ();
        bsg_adder_chunked_serial #(.width_p(32), .chunk_p(CH)) u_dut (
            .clk_i    (clk),
            .reset_n_i(rst_rand),
            .io       (r_if.slave)
        );

        initial begin
            logic [31:0] a, b, es;
            logic        sub, ec, eo;
            longint      r;
            int          n, sel;
            r_if.v_i    = 1'b0;
            r_if.a_i    = '0;
            r_if.b_i    = '0;
            r_if.sub_i  = 1'b0;
            r_if.yumi_i = 1'b0;
            repeat (6) @(negedge clk);
            for (int i = 0; i < NOPS; i++) begin
                a   = $urandom;
                b   = $urandom;
                sel = $urandom_range(0, 7);
                if (sel == 0) a = 32'hFFFF_FFFF;
                if (sel == 1) b = a;
                if (sel == 2) b = 32'h8000_0000;
                if (sel == 3) a = 32'h7FFF_FFFF;
                sub = 1'($urandom_range(0, 1));
                if (!sub) begin
                    {ec, es} = {1'b0, a} + {1'b0, b};
                    r = longint'($signed(a)) + longint'($signed(b));
                end else begin
                    es = a - b;
                    ec = (a >= b);
                    r  = longint'($signed(a)) - longint'($signed(b));
                end
                eo = (r > 64'sd2147483647) || (r < -64'sd2147483648);

                repeat ($urandom_range(0, 2)) @(negedge clk);
                n = 0;
                while (!r_if.ready_o && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                r_if.v_i   = 1'b1;
                r_if.a_i   = a;
                r_if.b_i   = b;
                r_if.sub_i = sub;
                @(negedge clk);
                r_if.v_i = 1'b0;
                r_if.a_i = $urandom;
                r_if.b_i = $urandom;
                n = 0;
                while (!r_if.v_o && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                check($sformatf("rand_ch%0d_lat", CH), 64'(n), 64'(NCH));
                repeat ($urandom_range(0, 3)) @(negedge clk);
                check($sformatf("rand_ch%0d_op%0d", CH, i),
                      {29'd0, r_if.v_o, r_if.c_o, r_if.ovf_o, r_if.sum_o},
                      {29'd0, 1'b1, ec, eo, es});
                if (r_if.v_o) begin
                    r_if.yumi_i = 1'b1;
                    @(negedge clk);
                    r_if.yumi_i = 1'b0;
                end
            end
            done = 1'b1;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [33:0] held;
        int          n;
        rst_dir     = 1'b0;
        rst_rand    = 1'b0;
        d_if.v_i    = 1'b0;
        d_if.a_i    = '0;
        d_if.b_i    = '0;
        d_if.sub_i  = 1'b0;
        d_if.yumi_i = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", {29'd0, d_if.ready_o, d_if.v_o, d_if.c_o, d_if.ovf_o, d_if.sum_o},
              {29'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0});
        rst_dir  = 1'b1;
        rst_rand = 1'b1;
        @(negedge clk);

        do_dir("add_ffff_1", 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1, 1'b0);
        do_dir("sub_5_7",    32'h5, 32'h7, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        do_dir("sub_7_5",    32'h7, 32'h5, 1'b1, 32'h2, 1'b1, 1'b0);
        do_dir("add_7fff_1", 32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        do_dir("sub_8000_1", 32'h8000_0000, 32'h1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

        // backpressure: hold the result for 10 cycles while v_i is pulsed
        d_if.v_i   = 1'b1;
        d_if.a_i   = 32'h1234_5000;
        d_if.b_i   = 32'h0000_0678;
        d_if.sub_i = 1'b0;
        @(negedge clk);
        d_if.v_i = 1'b0;
        n = 0;
        while (!d_if.v_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp_lat", 64'(n), 64'd4);
        held = {1'b0, 1'b0, 32'h1234_5678};
        for (int i = 0; i < 10; i++) begin
            d_if.v_i = 1'(i);
            d_if.a_i = 32'(i);
            d_if.b_i = 32'(i * 3);
            @(negedge clk);
            check("bp_hold", {28'd0, d_if.v_o, d_if.ready_o, d_if.c_o, d_if.ovf_o, d_if.sum_o},
                  {28'd0, 1'b1, 1'b0, held});
        end
        d_if.v_i = 1'b0;
        if (d_if.v_o) d_if.yumi_i = 1'b1;
        @(negedge clk);
        d_if.yumi_i = 1'b0;
        check("bp_release", {62'd0, d_if.ready_o, d_if.v_o}, 64'b10);
        @(negedge clk);
        check("bp_no_accept", {62'd0, d_if.ready_o, d_if.v_o}, 64'b10);

        // reset on the second BUSY cycle
        d_if.v_i   = 1'b1;
        d_if.a_i   = 32'h1111_1111;
        d_if.b_i   = 32'h2222_2222;
        d_if.sub_i = 1'b0;
        @(negedge clk);
        d_if.v_i = 1'b0;
        @(negedge clk);
        rst_dir = 1'b0;
        @(negedge clk);
        check("midreset", {29'd0, d_if.v_o, d_if.ready_o, d_if.c_o, d_if.ovf_o, d_if.sum_o},
              {29'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0});
        rst_dir = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("midreset_quiet", {62'd0, d_if.v_o, d_if.ready_o}, 64'b01);
        end
        do_dir("add_3_4", 32'h3, 32'h4, 1'b0, 32'h7, 1'b0, 1'b0);

        n = 0;
        while (!(g_rand[0].done && g_rand[1].done && g_rand[2].done) && n < 60000) begin
            @(negedge clk);
            n++;
        end
        check("rand_complete",
              {61'd0, g_rand[2].done, g_rand[1].done, g_rand[0].done}, 64'b111);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
